// File: rtl/conv_pkg.sv
// Shared definitions for the 3x3 convolution path.
// Row words pack three pixels: left in the MSBs, right in the LSBs.
package conv_pkg;

  localparam int PIX_W_DEF  = 16;
  localparam int ROW_W      = 3 * PIX_W_DEF;
  localparam int LEFT_MSB   = 47;
  localparam int CENTRE_MSB = 31;
  localparam int RIGHT_MSB  = 15;

endpackage

// File: rtl/line_buffer.sv
// Two-line pixel store {L2, L1}; one shared address.
// Reads are combinational and return the old word on a same-cycle write.
module line_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster pixel stream to 3x3 interior windows.
// Two line buffers plus three row shift registers; one-entry output stage.
module window_gen_3x3
  import conv_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PIX_W-1:0]   pix_data,
  input  logic               pix_valid,
  input  logic               pix_sof,
  output logic               pix_ready,
  output logic [3*PIX_W-1:0] im1,
  output logic [3*PIX_W-1:0] im2,
  output logic [3*PIX_W-1:0] im3,
  output logic               win_valid,
  input  logic               win_ready,
  output logic               win_last,
  output logic               frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

  logic [CW-1:0]      col;
  logic [CW-1:0]      cur_col;
  logic [RW-1:0]      row;
  logic [RW-1:0]      cur_row;
  logic               accept;
  logic               at_eol;
  logic               at_eof;
  logic               is_win;
  logic [PIX_W-1:0]   l1;
  logic [PIX_W-1:0]   l2;
  logic [2*PIX_W-1:0] lb_rd;
  logic [3*PIX_W-1:0] top_sr;
  logic [3*PIX_W-1:0] mid_sr;
  logic [3*PIX_W-1:0] bot_sr;
  logic [3*PIX_W-1:0] top_nx;
  logic [3*PIX_W-1:0] mid_nx;
  logic [3*PIX_W-1:0] bot_nx;

  assign pix_ready = !win_valid || win_ready;
  assign accept    = pix_valid && pix_ready;

  // sof restarts the raster at (0,0) for this pixel
  assign cur_col = pix_sof ? '0 : col;
  assign cur_row = pix_sof ? '0 : row;
  assign at_eol  = cur_col == COL_MAX;
  assign at_eof  = at_eol && (cur_row == ROW_MAX);
  assign is_win  = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (2 * PIX_W)
  ) u_line_buffer (
    .clk   (clk),
    .we    (accept),
    .addr  (cur_col),
    .wdata ({l1, pix_data}),
    .rdata (lb_rd)
  );

  assign l2 = lb_rd[2*PIX_W-1:PIX_W];
  assign l1 = lb_rd[PIX_W-1:0];

  assign top_nx = {top_sr[2*PIX_W-1:0], l2};
  assign mid_nx = {mid_sr[2*PIX_W-1:0], l1};
  assign bot_nx = {bot_sr[2*PIX_W-1:0], pix_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      top_sr     <= '0;
      mid_sr     <= '0;
      bot_sr     <= '0;
      im1        <= '0;
      im2        <= '0;
      im3        <= '0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && at_eof;
      if (accept) begin
        top_sr <= top_nx;
        mid_sr <= mid_nx;
        bot_sr <= bot_nx;
        if (at_eol) begin
          col <= '0;
          row <= at_eof ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
        win_valid <= is_win;
        win_last  <= is_win && at_eof;
        if (is_win) begin
          im1 <= top_nx;
          im2 <= mid_nx;
          im3 <= bot_nx;
        end
      end else if (win_ready) begin
        win_valid <= 1'b0;
        win_last  <= 1'b0;
      end
    end
  end

endmodule
